// File: rtl/irq_w1c_pkg.sv
// Shared constants for the W1C interrupt controller: register addresses and FSM state encoding.
package irq_w1c_pkg;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_VECTOR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index (bit 0 wins).
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_found,
  output logic [VEC_W-1:0] o_idx
);

  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = VEC_W'(i);
    end
  end

endmodule

// File: rtl/irq_w1c_ctrl.sv
// W1C status/enable bank with a fixed-priority IDLE/ASSERT/GAP sequencer driving irq/irq_vec.
// IRQ_W1C_COALESCE_EN stretches GAP to HOLDOFF cycles using a down-counter loaded on ack.
module irq_w1c_ctrl
  import irq_w1c_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
`ifdef IRQ_W1C_COALESCE_EN
  , parameter int HOLDOFF = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] i_src_evt,
  input  logic             i_reg_wr,
  input  logic [1:0]       i_reg_addr,
  input  logic [N_SRC-1:0] i_reg_wdat,
  output logic [31:0]      o_reg_rdat,
  output logic             o_irq,
  output logic [VEC_W-1:0] o_irq_vec,
  input  logic             i_irq_ack
);

  logic [N_SRC-1:0] r_status;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] w_pending;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ack_clr;
  logic             w_ack;
  logic             w_found;
  logic [VEC_W-1:0] w_enc_idx;

  irq_state_e       r_state;
  irq_state_e       w_state_nxt;
  logic             r_irq;
  logic [VEC_W-1:0] r_vec;
  logic             w_irq_nxt;
  logic [VEC_W-1:0] w_vec_nxt;
  logic             w_gap_done;

  assign w_pending = r_status & r_enable;
  assign w_ack     = i_irq_ack && (r_state == ASSERT);
  assign w_w1c     = (i_reg_wr && (i_reg_addr == ADDR_STATUS)) ? i_reg_wdat : '0;
  assign w_ack_clr = w_ack ? (N_SRC'(1) << r_vec) : '0;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .VEC_W (VEC_W)
  ) u_prio_enc (
    .i_req   (w_pending),
    .o_found (w_found),
    .o_idx   (w_enc_idx)
  );

  // A new event always beats a same-cycle clear from software or from the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
      r_enable <= '0;
    end else begin
      r_status <= i_src_evt | (r_status & ~(w_w1c | w_ack_clr));
      if (i_reg_wr && (i_reg_addr == ADDR_ENABLE)) r_enable <= i_reg_wdat;
    end
  end

`ifdef IRQ_W1C_COALESCE_EN
  localparam int CNT_W = $clog2(HOLDOFF + 1);
  logic [CNT_W-1:0] r_hold;

  // Loaded with HOLDOFF-1 so that GAP spans exactly HOLDOFF cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_ack) begin
      r_hold <= CNT_W'(HOLDOFF - 1);
    end else if ((r_state == GAP) && (r_hold != '0)) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  assign w_gap_done = (r_hold == '0);
`else
  assign w_gap_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = ASSERT;
      ASSERT: begin
        if (w_ack)                   w_state_nxt = GAP;
        else if (!w_pending[r_vec])  w_state_nxt = IDLE;
      end
      GAP:     if (w_gap_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_irq_nxt = (w_state_nxt == ASSERT);
    w_vec_nxt = r_vec;
    if ((r_state == IDLE) && w_found) w_vec_nxt = w_enc_idx;
  end

  assign o_irq     = r_irq;
  assign o_irq_vec = r_vec;

  always_comb begin
    o_reg_rdat = '0;
    case (i_reg_addr)
      ADDR_STATUS:  o_reg_rdat = 32'(r_status);
      ADDR_ENABLE:  o_reg_rdat = 32'(r_enable);
      ADDR_PENDING: o_reg_rdat = 32'(w_pending);
      ADDR_VECTOR:  o_reg_rdat = 32'({r_irq, r_vec});
      default:      o_reg_rdat = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_w1c_ctrl.sv
// Directed self-checking bench for irq_w1c_ctrl (N_SRC=8): one task per scenario, inline comparisons.
module tb_irq_w1c_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  src_evt;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdat;
  logic [31:0] reg_rdat;
  logic        irq;
  logic [2:0]  irq_vec;
  logic        irq_ack;

  int total = 0;
  int bad   = 0;

  irq_w1c_ctrl #(.N_SRC(8), .VEC_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_src_evt  (src_evt),
    .i_reg_wr   (reg_wr),
    .i_reg_addr (reg_addr),
    .i_reg_wdat (reg_wdat),
    .o_reg_rdat (reg_rdat),
    .o_irq      (irq),
    .o_irq_vec  (irq_vec),
    .i_irq_ack  (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdat = d;
    tick();
    reg_wr = 1'b0; reg_wdat = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdat;
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b want=0", irq); end
    total++; if (irq_vec !== 3'd0) begin bad++; $display("FAIL reset_vec got=%0d want=0", irq_vec); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h want=0", a, d); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wr(2'd1, 8'hFF);
    src_evt = 8'h20;
    tick();
    src_evt = 8'h00;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_n1 got=%0b want=0", irq); end
    rd(2'd0, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL basic_status_set got=%h want=20", d); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_n2 got=%0b want=1", irq); end
    total++; if (irq_vec !== 3'd5) begin bad++; $display("FAIL basic_vec got=%0d want=5", irq_vec); end
    rd(2'd3, d);
    total++; if (d !== 32'hD) begin bad++; $display("FAIL basic_vector_reg got=%h want=d", d); end
    ack_once();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_after_ack got=%0b want=0", irq); end
    rd(2'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL basic_status_clr got=%h want=0", d); end
    tick(); tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_no_reassert got=%0b want=0", irq); end
  endtask

  task automatic test_enable_late();
    logic [31:0] d;
    wr(2'd1, 8'h00);
    src_evt = 8'h28;
    tick();
    src_evt = 8'h00;
    tick(); tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL en0_irq got=%0b want=0", irq); end
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL en0_pending got=%h want=0", d); end
    ack_once();
    rd(2'd0, d);
    total++; if (d !== 32'h28) begin bad++; $display("FAIL en0_stray_ack got=%h want=28", d); end
    wr(2'd1, 8'h08);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL en_late_w1 got=%0b want=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL en_late_w2 got=%0b want=1", irq); end
    total++; if (irq_vec !== 3'd3) begin bad++; $display("FAIL en_late_vec got=%0d want=3", irq_vec); end
    ack_once();
    rd(2'd0, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL en_late_status got=%h want=20", d); end
    tick(); tick(); tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL en_late_quiet got=%0b want=0", irq); end
    wr(2'd0, 8'h20);
    rd(2'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h want=0", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    wr(2'd1, 8'hFF);
    src_evt = 8'h04;
    tick(); tick();
    total++; if (irq !== 1'b1 || irq_vec !== 3'd2) begin bad++; $display("FAIL setwin_first got=%0b/%0d want=1/2", irq, irq_vec); end
    ack_once();
    src_evt = 8'h00;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL setwin_gap got=%0b want=0", irq); end
    rd(2'd0, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL setwin_status got=%h want=4", d); end
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL setwin_idle got=%0b want=0", irq); end
    tick();
    total++; if (irq !== 1'b1 || irq_vec !== 3'd2) begin bad++; $display("FAIL setwin_reassert got=%0b/%0d want=1/2", irq, irq_vec); end
    ack_once();
    tick(); tick();
    rd(2'd0, d);
    total++; if (d !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL setwin_drain got=%h/%0b want=0/0", d, irq); end
  endtask

  task automatic test_sw_clear();
    logic [31:0] d;
    src_evt = 8'h10;
    tick();
    src_evt = 8'h00;
    tick();
    total++; if (irq !== 1'b1 || irq_vec !== 3'd4) begin bad++; $display("FAIL swclr_assert got=%0b/%0d want=1/4", irq, irq_vec); end
    wr(2'd0, 8'h10);
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL swclr_drop got=%0b want=0", irq); end
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL swclr_pending got=%h want=0", d); end
    // FSM is back in IDLE, so a fresh event must raise irq two cycles later.
    src_evt = 8'h02;
    tick();
    src_evt = 8'h00;
    tick();
    total++; if (irq !== 1'b1 || irq_vec !== 3'd1) begin bad++; $display("FAIL swclr_idle got=%0b/%0d want=1/1", irq, irq_vec); end
    ack_once();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int low;
    src_evt = 8'h81;
    tick();
    src_evt = 8'h00;
    tick();
    total++; if (irq !== 1'b1 || irq_vec !== 3'd0) begin bad++; $display("FAIL b2b_first got=%0b/%0d want=1/0", irq, irq_vec); end
    ack_once();
    low = 0;
    while (irq !== 1'b1 && low < 20) begin
      low++;
      tick();
    end
    total++; if (irq !== 1'b1 || low < 1) begin bad++; $display("FAIL b2b_second got=%0b low=%0d want=1 low>=1", irq, low); end
`ifndef IRQ_W1C_COALESCE_EN
    total++; if (low != 2) begin bad++; $display("FAIL b2b_gap_len got=%0d want=2", low); end
`endif
    total++; if (irq_vec !== 3'd7) begin bad++; $display("FAIL b2b_vec got=%0d want=7", irq_vec); end
    ack_once();
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    src_evt = 8'h40;
    tick();
    src_evt = 8'h00;
    tick(); tick(); tick(); tick(); tick(); tick();
    total++; if (irq !== 1'b1 || irq_vec !== 3'd6) begin bad++; $display("FAIL arst_pre got=%0b/%0d want=1/6", irq, irq_vec); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%0b want=0", irq); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL arst_reg%0d got=%h want=0", a, d); end
    end
  endtask

  initial begin
    rst_n = 1'b0; src_evt = 8'h00; reg_wr = 1'b0; reg_addr = 2'd0; reg_wdat = 8'h00; irq_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_enable_late();
    test_set_wins();
    test_sw_clear();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
